// File: rtl/regarb_pkg.sv
// Shared widths and state encoding for the register file write arbiter.
package regarb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    CLR_HI,
    CLR_LO,
    IDLE,
    WRITE
  } state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle: NUM_REQ requesters, valid/ready handshake.
interface regfile_write_arbiter_if
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [REG_ADDR_W*NUM_REQ-1:0] req_addr;
  logic [REG_DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// One-hot arbiter: round-robin from ptr, or lowest index wins when
// REGARB_FIXED_PRIO_EN is defined (ptr port removed in that build).
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef REGARB_FIXED_PRIO_EN
  input  logic [1:0]         ptr,
`endif
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    logic found;
    int   j;
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef REGARB_FIXED_PRIO_EN
      j = i;
`else
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
`endif
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Clears the 32x32 register file after reset, then shares its write port.
// Build option REGARB_FIXED_PRIO_EN selects fixed-priority arbitration.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave req,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [REG_DATA_W-1:0] WriteData,
  output logic                  RegWrite,
  output logic                  init_done,
  output logic [1:0]            grant_idx
);

  state_t                  state, state_d;
  logic [REG_ADDR_W-1:0]   idx, idx_d;
  logic [NUM_REQ-1:0]      grant, ready;
  logic                    hs;
  logic [REG_ADDR_W-1:0]   sel_addr;
  logic [REG_DATA_W-1:0]   sel_data;
  logic [1:0]              sel_idx;
  logic                    we_d, done_d;
  logic [REG_ADDR_W-1:0]   wreg_d;
  logic [REG_DATA_W-1:0]   wdata_d;
  logic [1:0]              gidx_d;

`ifndef REGARB_FIXED_PRIO_EN
  logic [1:0] ptr;
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req  (req.req_valid),
`ifndef REGARB_FIXED_PRIO_EN
    .ptr  (ptr),
`endif
    .grant(grant)
  );

  assign ready         = (state == IDLE) ? grant : '0;
  assign req.req_ready = ready;
  assign hs            = |ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req.req_data[i*REG_DATA_W +: REG_DATA_W];
        sel_idx  = 2'(i);
      end
    end
  end

  // Output registers load from the state being left, so the
  // strobe lands in the cycle after CLR_HI or the handshake.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    we_d    = 1'b0;
    done_d  = init_done;
    wreg_d  = WriteReg;
    wdata_d = WriteData;
    gidx_d  = grant_idx;
    unique case (state)
      CLR_HI: begin
        we_d    = 1'b1;
        wreg_d  = idx;
        wdata_d = '0;
        state_d = CLR_LO;
      end
      CLR_LO: begin
        if (idx == REG_ADDR_W'(NUM_REGS - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx + 1'b1;
          state_d = CLR_HI;
        end
      end
      IDLE: begin
        if (hs) begin
          we_d    = |sel_addr;
          wreg_d  = sel_addr;
          wdata_d = sel_data;
          gidx_d  = sel_idx;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLR_HI;
      idx       <= '0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      init_done <= 1'b0;
      grant_idx <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      RegWrite  <= we_d;
      WriteReg  <= wreg_d;
      WriteData <= wdata_d;
      init_done <= done_d;
      grant_idx <= gidx_d;
    end
  end

`ifndef REGARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (sel_idx == 2'(NUM_REQ - 1)) ? 2'd0 : sel_idx + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NUM_REQ=2).
module tb_regfile_write_arbiter;

`ifdef REGARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic        init_done;
  logic [1:0]  grant_idx;

  int nvec = 0;
  int nerr = 0;

  regfile_write_arbiter_if #(.NUM_REQ(2)) bus ();

  regfile_write_arbiter #(
    .NUM_REQ(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .RegWrite (RegWrite),
    .init_done(init_done),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  rdy;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [1:0]  gidx;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [31:0] d0,
                       input logic [31:0] d1);
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic prev_we;
    logic exp_we;
    logic [1:0] w;

    tbl[0] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
               2'b01, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0};
    if (FIXED)
      tbl[1] = '{2'b11, 5'd7, 5'd9, 32'h1111, 32'h2222,
                 2'b01, 1'b1, 5'd7, 32'h1111, 2'd0};
    else
      tbl[1] = '{2'b11, 5'd7, 5'd9, 32'h1111, 32'h2222,
                 2'b10, 1'b1, 5'd9, 32'h2222, 2'd1};
    tbl[2] = '{2'b11, 5'd3, 5'd4, 32'h3333, 32'h4444,
               2'b01, 1'b1, 5'd3, 32'h3333, 2'd0};
    tbl[3] = '{2'b01, 5'd31, 5'd0, 32'hFFFFFFFF, 32'h0,
               2'b01, 1'b1, 5'd31, 32'hFFFFFFFF, 2'd0};
    tbl[4] = '{2'b10, 5'd0, 5'd0, 32'h0, 32'h1234,
               2'b10, 1'b0, 5'd0, 32'h1234, 2'd1};
    tbl[5] = '{2'b10, 5'd0, 5'd12, 32'h0, 32'hABCD,
               2'b10, 1'b1, 5'd12, 32'hABCD, 2'd1};
    tbl[6] = '{2'b00, 5'd1, 5'd2, 32'h5, 32'h6,
               2'b00, 1'b0, 5'd12, 32'hABCD, 2'd1};

    drive(2'b11, 5'd1, 5'd2, 32'h11, 32'h22);
    rst = 1'b1;
    repeat (3) next_cycle();
    chk("rst_we", 32'(RegWrite), 32'd0);
    chk("rst_wreg", 32'(WriteReg), 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_gidx", 32'(grant_idx), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);

    // clear sequence with both requesters already pending
    rst = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      next_cycle();
      exp_we = (n % 2 == 1) && (n <= 63);
      chk("clr_we", 32'(RegWrite), 32'(exp_we));
      if (exp_we) begin
        chk("clr_wreg", 32'(WriteReg), 32'((n - 1) / 2));
        chk("clr_wdata", WriteData, 32'd0);
      end
      chk("clr_done", 32'(init_done), 32'(n >= 64));
      chk("clr_ready", 32'(bus.req_ready), (n >= 64) ? 32'd1 : 32'd0);
    end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    next_cycle();
    chk("idle_we", 32'(RegWrite), 32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      next_cycle();
      chk($sformatf("v%0d_we", i), 32'(RegWrite), 32'(tbl[i].we));
      chk($sformatf("v%0d_wreg", i), 32'(WriteReg), 32'(tbl[i].wreg));
      chk($sformatf("v%0d_wdata", i), WriteData, tbl[i].wdata);
      chk($sformatf("v%0d_gidx", i), 32'(grant_idx), 32'(tbl[i].gidx));
      chk($sformatf("v%0d_busy", i), 32'(bus.req_ready), 32'd0);
      drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      next_cycle();
      chk($sformatf("v%0d_low", i), 32'(RegWrite), 32'd0);
    end

    // both requesters held: one write every other cycle
    drive(2'b11, 5'd1, 5'd2, 32'hA0, 32'hB1);
    prev_we = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) next_cycle();
      w = (FIXED || ((c / 2) % 2 == 0)) ? 2'b01 : 2'b10;
      if (c % 2 == 0) begin
        #1;
        chk("alt_ready", 32'(bus.req_ready), 32'(w));
        chk("alt_we0", 32'(RegWrite), 32'd0);
      end else begin
        chk("alt_we1", 32'(RegWrite), 32'd1);
        chk("alt_wreg", 32'(WriteReg), (w == 2'b01) ? 32'd1 : 32'd2);
        chk("alt_gidx", 32'(grant_idx), (w == 2'b01) ? 32'd0 : 32'd1);
      end
      chk("alt_gap", 32'(prev_we && RegWrite), 32'd0);
      prev_we = RegWrite;
    end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    next_cycle();

    // reset lands on the WRITE cycle of an accepted request
    drive(2'b01, 5'd20, 5'd0, 32'h5555, 32'h0);
    #1;
    chk("rw_ready", 32'(bus.req_ready), 32'd1);
    next_cycle();
    chk("rw_we", 32'(RegWrite), 32'd1);
    rst = 1'b1;
    next_cycle();
    chk("rw_rst_we", 32'(RegWrite), 32'd0);
    chk("rw_rst_wreg", 32'(WriteReg), 32'd0);
    chk("rw_rst_wdata", WriteData, 32'd0);
    chk("rw_rst_done", 32'(init_done), 32'd0);
    chk("rw_rst_gidx", 32'(grant_idx), 32'd0);
    chk("rw_rst_ready", 32'(bus.req_ready), 32'd0);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      next_cycle();
      chk("rw_clr_we", 32'(RegWrite), 32'(n % 2));
      if (n % 2 == 1) begin
        chk("rw_clr_wreg", 32'(WriteReg), 32'((n - 1) / 2));
        chk("rw_clr_wdata", WriteData, 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Sequences and shares the single write port of the 32x32 register file. After reset it clears all 32 registers, since the register file only initialises r0. It then arbitrates round-robin between NUM_REQ writeback requesters using valid/ready handshakes. The register file writes on the rising edge of RegWrite, so the block drives RegWrite as a one-cycle pulse that is always followed by at least one low cycle.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  5*NUM_REQ  destination register; requester i uses bits [5i+4:5i]
req_data  in  32*NUM_REQ  write data; requester i uses bits [32i+31:32i]
req_ready  out  NUM_REQ  one-hot grant; the handshake completes when valid&&ready at a rising clk edge
WriteReg  out  5  register file write address (registered)
WriteData  out  32  register file write data (registered)
RegWrite  out  1  register file write strobe (registered, one-cycle pulse)
init_done  out  1  high once the clear sequence has completed
grant_idx  out  2  index of the last granted requester (registered)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: RegWrite=0, WriteReg=0, WriteData=0, init_done=0, grant_idx=0, req_ready=0. RR pointer set so requester 0 has top priority. State=CLR_HI, clear index=0.
- Cycle numbering: cycle n is the cycle after the n-th rising edge at which rst is sampled low.
- States:
  - CLR_HI: RegWrite=1, WriteReg=idx, WriteData=0. Next state CLR_LO.
  - CLR_LO: RegWrite=0. If idx==31, go to IDLE and set init_done=1. Otherwise idx+1, go to CLR_HI.
  - IDLE: RegWrite=0. req_ready is combinational: the one-hot of the RR winner among req_valid, all zero if none valid. On a handshake, latch addr and data and go to WRITE.
  - WRITE: RegWrite=1 with the latched addr and data; req_ready=0. Next state IDLE.
- Clear timing: RegWrite is high in cycles 1,3,...,63 with WriteReg 0..31. init_done=1 from cycle 64, which is also the first cycle req_ready can be asserted.
- req_ready is 0 in CLR_HI, CLR_LO and WRITE regardless of req_valid.
- Write latency: handshake in cycle k gives RegWrite=1 in cycle k+1 and RegWrite=0 in cycle k+2. Peak throughput is one write per 2 cycles.
- RegWrite is never high in two consecutive cycles.
- Write to r0: accepted normally and occupies the WRITE slot, but RegWrite stays 0. WriteReg and WriteData still update.
- Round-robin: after granting i, priority order is i+1, i+2, ... modulo NUM_REQ. The pointer advances only on a completed handshake. A requester that does not win keeps its request pending.
- req_addr and req_data must be stable while valid&&!ready. Dropping valid before the handshake is allowed and causes no write.
- Reset mid-operation: the next cycle has RegWrite=0 and all reset values. An accepted but not yet pulsed write is dropped. The clear sequence restarts from address 0.
- grant_idx updates on each handshake.

Optional Feature:
REGARB_FIXED_PRIO_EN. When defined, arbitration is fixed priority with the lowest index winning, and the RR pointer logic is removed. When undefined, the round-robin arbitration above applies.

Decomposition:
- Package regarb_pkg holds REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32 and the state encoding (CLR_HI, CLR_LO, IDLE, WRITE).
- One sub-module, rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant out. It also contains the fixed-priority variant under the macro.

Test Plan:
1. Release rst with req_valid=2'b11 held → RegWrite pulses in cycles 1..63 (odd) at addr 0..31 with data 0; req_ready=0 throughout; init_done=1 at cycle 64.
2. After init, req0 only, addr=5, data=0xDEADBEEF → req_ready=01 in the same cycle; next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; following cycle RegWrite=0.
3. Both requesters held valid for 8 grants → grant order 0,1,0,1,...; RegWrite high every other cycle, never two consecutive.
4. req1 writes addr=0, data=0x1234 → handshake completes; RegWrite stays 0 for that slot; the next request is accepted 2 cycles later.
5. Assert rst during the WRITE cycle → RegWrite=0 the next cycle; after release the clear restarts at addr 0; the pending write never appears.
6. With REGARB_FIXED_PRIO_EN defined, both requesters held valid → req0 wins every arbitration and req1 is never granted.
